// File: rtl/seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_pkg : shared state encoding and stage constants for the        |
// |           fclk step sequencer.             Revision 1.0            |
// +----------------------------------------------------------------------+
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } seq_state_t;

  localparam int STG_FETCH     = 0;
  localparam int STG_DECODE    = 1;
  localparam int STG_EXECUTE   = 2;
  localparam int STG_MEM       = 3;
  localparam int STG_WRITEBACK = 4;

  localparam int DEFAULT_NUM_STAGES = 5;

endpackage
`default_nettype wire

// File: rtl/fclk_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fclk_edge_detect : rising-edge detector on fclk, registered tick.  |
// |   Optional two-flop synchronizer via FCLK_SYNC_EN.  Revision 1.0   |
// +----------------------------------------------------------------------+
module fclk_edge_detect (
  input  logic CLK,
  input  logic rst,
  input  logic i_fclk,
  output logic o_tick
);

  logic w_fclk_s;
  logic r_prev;
  logic r_tick;

`ifdef FCLK_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_fclk;
      r_sync2 <= r_sync1;
    end
  end

  assign w_fclk_s = r_sync2;
`else
  // fclk is assumed to be generated synchronously from CLK here
  assign w_fclk_s = i_fclk;
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_prev <= w_fclk_s;
      r_tick <= w_fclk_s & ~r_prev;
    end
  end

  assign o_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/fclk_step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fclk_step_sequencer : turns fclk edges into one-hot stage enables  |
// |   under run/step/halt/stall control. Macro: FCLK_SYNC_EN. Rev 1.0  |
// +----------------------------------------------------------------------+
module fclk_step_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_STAGES = DEFAULT_NUM_STAGES,
  parameter int CNT_W      = 16
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic                          fclk,
  input  logic                          run,
  input  logic                          step,
  input  logic                          halt_req,
  input  logic                          stall,
  output logic [NUM_STAGES-1:0]         stage_en,
  output logic [$clog2(NUM_STAGES)-1:0] stage_idx,
  output logic                          instr_done,
  output logic [CNT_W-1:0]              retired_cnt,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE_EN = NUM_STAGES'(1);

  seq_state_t              r_state;
  seq_state_t              w_state_nxt;
  logic                    w_tick;
  logic                    w_act;
  logic                    w_last;
  logic [NUM_STAGES-1:0]   r_stage_en;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_instr_done;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_busy;

  fclk_edge_detect u_edge (
    .CLK    (CLK),
    .rst    (rst),
    .i_fclk (fclk),
    .o_tick (w_tick)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Ticks landing while IDLE are dropped, including the one on the leaving edge
  always_comb begin
    w_state_nxt = r_state;
    w_act       = w_tick && (r_state != ST_IDLE) && !stall;
    w_last      = w_act && (r_idx == LAST_IDX);
    case (r_state)
      ST_IDLE: begin
        if (run && !halt_req) w_state_nxt = ST_RUN;
        else if (step)        w_state_nxt = ST_STEP;
      end
      ST_RUN: begin
        if (w_last && (halt_req || !run)) w_state_nxt = ST_IDLE;
      end
      ST_STEP: begin
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_stage_en   <= '0;
      r_idx        <= '0;
      r_instr_done <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_stage_en   <= w_act ? (ONE_EN << r_idx) : '0;
      r_instr_done <= w_last;
      // busy lags the state by one cycle so it drops after instr_done
      r_busy       <= (r_state != ST_IDLE);
      if (w_last)      r_idx <= '0;
      else if (w_act)  r_idx <= r_idx + IDX_W'(1);
      if (w_last)      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign stage_en    = r_stage_en;
  assign stage_idx   = r_idx;
  assign instr_done  = r_instr_done;
  assign retired_cnt = r_cnt;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fclk_step_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fclk_step_sequencer : directed self-checking bench.             |
// |   Honours FCLK_SYNC_EN for expected latency.       Revision 1.0    |
// +----------------------------------------------------------------------+
module tb_fclk_step_sequencer;
  import seq_pkg::*;

`ifdef FCLK_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        fclk = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        halt_req = 1'b0;
  logic        stall = 1'b0;
  logic [4:0]  stage_en;
  logic [2:0]  stage_idx;
  logic        instr_done;
  logic [15:0] retired_cnt;
  logic        busy;
  logic [4:0]  stage_en2;
  logic [2:0]  stage_idx2;
  logic        instr_done2;
  logic [1:0]  retired_cnt2;
  logic        busy2;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  fclk_step_sequencer dut (
    .CLK(CLK), .rst(rst), .fclk(fclk), .run(run), .step(step),
    .halt_req(halt_req), .stall(stall), .stage_en(stage_en),
    .stage_idx(stage_idx), .instr_done(instr_done),
    .retired_cnt(retired_cnt), .busy(busy)
  );

  // Narrow-counter instance sharing the same stimulus, for counter wrap
  fclk_step_sequencer #(.NUM_STAGES(5), .CNT_W(2)) dut2 (
    .CLK(CLK), .rst(rst), .fclk(fclk), .run(run), .step(step),
    .halt_req(halt_req), .stall(stall), .stage_en(stage_en2),
    .stage_idx(stage_idx2), .instr_done(instr_done2),
    .retired_cnt(retired_cnt2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One fclk period; checks the enable/done pulse LAT cycles after the sampled edge
  task automatic fpulse(input string tag, input logic [4:0] exp_en, input logic exp_done);
    @(negedge CLK); fclk = 1'b1;
    @(posedge CLK);
    repeat (LAT - 1) @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_en"}, 32'(stage_en), 32'(exp_en));
    chk({tag, "_done"}, 32'(instr_done), 32'(exp_done));
    @(negedge CLK); fclk = 1'b0;
    chk({tag, "_en_off"}, 32'(stage_en), 32'd0);
    repeat (LAT + 1) @(negedge CLK);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_en", 32'(stage_en), 0);
    chk("rst_idx", 32'(stage_idx), 0);
    chk("rst_done", 32'(instr_done), 0);
    chk("rst_cnt", 32'(retired_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // idle: fclk edges are dropped
    repeat (3) fpulse("idle", 5'd0, 1'b0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cnt", 32'(retired_cnt), 0);

    // free run for 10 edges; run drops before the last WRITEBACK
    @(negedge CLK); run = 1'b1;
    repeat (2) @(negedge CLK);
    chk("run_busy", 32'(busy), 1);
    fpulse("run0", 5'd1, 1'b0);
    fpulse("run1", 5'd2, 1'b0);
    fpulse("run2", 5'd4, 1'b0);
    fpulse("run3", 5'd8, 1'b0);
    fpulse("run4", 5'd16, 1'b1);
    fpulse("run5", 5'd1, 1'b0);
    fpulse("run6", 5'd2, 1'b0);
    fpulse("run7", 5'd4, 1'b0);
    fpulse("run8", 5'd8, 1'b0);
    run = 1'b0;
    fpulse("run9", 5'd16, 1'b1);
    chk("run_cnt", 32'(retired_cnt), 2);
    chk("run_idx", 32'(stage_idx), 0);
    chk("run_idle", 32'(busy), 0);

    // single step: one instruction, extra edges ignored
    @(negedge CLK); step = 1'b1;
    @(negedge CLK); step = 1'b0;
    fpulse("st0", 5'd1, 1'b0);
    fpulse("st1", 5'd2, 1'b0);
    fpulse("st2", 5'd4, 1'b0);
    fpulse("st3", 5'd8, 1'b0);
    fpulse("st4", 5'd16, 1'b1);
    fpulse("st5", 5'd0, 1'b0);
    fpulse("st6", 5'd0, 1'b0);
    chk("st_idx", 32'(stage_idx), 0);
    chk("st_cnt", 32'(retired_cnt), 3);
    chk("st_busy", 32'(busy), 0);

    // halt after DECODE completes the instruction, then stops
    @(negedge CLK); run = 1'b1;
    fpulse("h0", 5'd1, 1'b0);
    fpulse("h1", 5'd2, 1'b0);
    halt_req = 1'b1;
    fpulse("h2", 5'd4, 1'b0);
    fpulse("h3", 5'd8, 1'b0);
    fpulse("h4", 5'd16, 1'b1);
    run = 1'b0;
    halt_req = 1'b0;
    fpulse("h5", 5'd0, 1'b0);
    chk("h_cnt", 32'(retired_cnt), 4);
    chk("h_busy", 32'(busy), 0);

    // stall at MEM holds the index; step pulses in RUN ignored
    @(negedge CLK); run = 1'b1;
    fpulse("s0", 5'd1, 1'b0);
    @(negedge CLK); step = 1'b1;
    @(negedge CLK); step = 1'b0;
    fpulse("s1", 5'd2, 1'b0);
    fpulse("s2", 5'd4, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fpulse("stall", 5'd0, 1'b0);
      chk("stall_idx", 32'(stage_idx), STG_MEM);
    end
    stall = 1'b0;
    fpulse("s3", 5'd8, 1'b0);
    run = 1'b0;
    fpulse("s4", 5'd16, 1'b1);
    chk("s_cnt", 32'(retired_cnt), 5);
    chk("wrap_cnt", 32'(retired_cnt2), 1);

    // reset mid-EXECUTE, asserted while the EXECUTE enable is high
    @(negedge CLK); run = 1'b1;
    fpulse("r0", 5'd1, 1'b0);
    fpulse("r1", 5'd2, 1'b0);
    @(negedge CLK); fclk = 1'b1;
    @(posedge CLK);
    repeat (LAT - 1) @(posedge CLK);
    @(negedge CLK);
    chk("r2_en", 32'(stage_en), 4);
    run = 1'b0;
    rst = 1'b1;
    #1;
    chk("ar_en", 32'(stage_en), 0);
    chk("ar_idx", 32'(stage_idx), 0);
    chk("ar_done", 32'(instr_done), 0);
    chk("ar_cnt", 32'(retired_cnt), 0);
    chk("ar_busy", 32'(busy), 0);
    fclk = 1'b0;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    fpulse("ar_idle", 5'd0, 1'b0);
    chk("ar_cnt2", 32'(retired_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
